// File: rtl/rv_pipe_skid_reg.sv
// Two-entry ready/valid pipeline register (main + skid) with per-thread and global flush.
// in_ready and all outputs come straight from flops, so no combinational path crosses the block.
module rv_pipe_skid_reg #(
  parameter int                WIDTH     = 256,
  parameter int                TID_W     = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TID_W-1:0]  in_tid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TID_W-1:0]  out_tid,
  output logic [WIDTH-1:0]  out_data,
  input  logic              flush_en,
  input  logic [TID_W-1:0]  flush_tid,
  input  logic              flush_all,
  output logic [1:0]        occupancy
);

  // Encoding doubles as the occupancy count; skid-without-main is unrepresentable.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

  typedef struct packed {
    logic [TID_W-1:0] tid;
    logic [WIDTH-1:0] data;
  } beat_t;

  state_e state_q, state_d;
  beat_t  main_q, main_d, skid_q, skid_d, in_beat;
  logic   main_v, skid_v, in_fire, out_fire;

  assign in_beat   = '{tid: in_tid, data: in_data};
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_tid   = main_q.tid;
  assign out_data  = main_q.data;
  assign occupancy = state_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  function automatic logic flush_hit(input logic [TID_W-1:0] t);
    return flush_all | (flush_en & (t == flush_tid));
  endfunction

  always_comb begin
    main_d  = main_q;
    skid_d  = skid_q;
    main_v  = (state_q != EMPTY);
    skid_v  = (state_q == FULL);
    state_d = state_q;
    // Handshake first, then flush kills, then compaction.
    case (state_q)
      EMPTY: if (in_fire) begin
        main_v = 1'b1;
        main_d = in_beat;
      end
      ONE: begin
        if (in_fire && out_fire) main_d = in_beat;
        else if (in_fire) begin
          skid_v = 1'b1;
          skid_d = in_beat;
        end else if (out_fire) main_v = 1'b0;
      end
      FULL: if (out_fire) begin
        main_d = skid_q;
        skid_v = 1'b0;
      end
      default: begin
        main_v = 1'b0;
        skid_v = 1'b0;
      end
    endcase
    if (main_v && flush_hit(main_d.tid)) main_v = 1'b0;
    if (skid_v && flush_hit(skid_d.tid)) skid_v = 1'b0;
    if (!main_v && skid_v) begin
      main_d = skid_d;
      main_v = 1'b1;
      skid_v = 1'b0;
    end
    state_d = skid_v ? FULL : (main_v ? ONE : EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '{tid: '0, data: RESET_VAL};
      skid_q  <= '{tid: '0, data: RESET_VAL};
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_rv_pipe_skid_reg.sv
// Scoreboard bench: driver pushes accepted beats into a FIFO model, monitor pops on output fire.
module tb_rv_pipe_skid_reg;
  localparam int W = 16;
  localparam logic [W-1:0] RV = 16'hDEAD;

  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [1:0] in_tid = '0, out_tid, flush_tid = '0, occupancy;
  logic [W-1:0] in_data = '0, out_data;
  logic flush_en = 1'b0, flush_all = 1'b0;

  typedef struct packed { logic [1:0] tid; logic [W-1:0] data; } beat_t;
  beat_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  logic mdl_rdy = 1'b1;

  rv_pipe_skid_reg #(.WIDTH(W), .TID_W(2), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_tid(in_tid), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_tid(out_tid), .out_data(out_data), .flush_en(flush_en), .flush_tid(flush_tid),
    .flush_all(flush_all), .occupancy(occupancy));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: an output beat fires at the coming edge; it must be the oldest model beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out", {14'd0, out_tid, out_data}, 32'hFFFF_FFFF);
      else begin
        beat_t b;
        b = exp_q.pop_front();
        chk("out_beat", {14'd0, out_tid, out_data}, {14'd0, b.tid, b.data});
      end
    end
  end

  // One clock of stimulus; model updates after the monitor's pop, then state is checked post-edge.
  task automatic cyc(input logic iv, input logic [1:0] it, input logic [W-1:0] id,
                     input logic ordy, input logic fe, input logic [1:0] ft, input logic fa);
    in_valid = iv; in_tid = it; in_data = id; out_ready = ordy;
    flush_en = fe; flush_tid = ft; flush_all = fa;
    @(negedge clk); #1;
    if (rst) exp_q.delete();
    else begin
      if (iv && mdl_rdy) exp_q.push_back('{tid: it, data: id});
      if (fa) exp_q.delete();
      else if (fe)
        for (int i = exp_q.size() - 1; i >= 0; i--)
          if (exp_q[i].tid == ft) exp_q.delete(i);
    end
    @(posedge clk); #1;
    mdl_rdy = (exp_q.size() < 2);
    chk("occupancy", {30'd0, occupancy}, exp_q.size());
    chk("in_ready", {31'd0, in_ready}, {31'd0, mdl_rdy});
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
    if (exp_q.size() > 0) chk("out_front", {14'd0, out_tid, out_data}, {14'd0, exp_q[0].tid, exp_q[0].data});
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 2'd0, '0, ordy, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic do_reset(input logic iv);
    rst = 1'b1;
    cyc(iv, 2'd3, 16'h5A5A, 1'b0, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    chk("rst_out_data", {16'd0, out_data}, {16'd0, RV});
    chk("rst_out_tid", {30'd0, out_tid}, 32'd0);
    chk("rst_occ", {30'd0, occupancy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset(1'b0);

    // Basic 1-cycle latency
    cyc(1'b1, 2'd1, 16'h00A5, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_tid", {30'd0, out_tid}, 32'd1);
    chk("lat_data", {16'd0, out_data}, 32'h00A5);
    chk("lat_occ", {30'd0, occupancy}, 32'd1);
    idle(1'b1);

    // Fill to FULL with backpressure, hold, then flush the main entry's thread
    cyc(1'b1, 2'd0, 16'h0011, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc(1'b1, 2'd1, 16'h0022, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("full_occ", {30'd0, occupancy}, 32'd2);
    chk("full_rdy", {31'd0, in_ready}, 32'd0);
    chk("full_data", {16'd0, out_data}, 32'h0011);
    cyc(1'b1, 2'd2, 16'h00EE, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("hold_data", {16'd0, out_data}, 32'h0011);
    cyc(1'b0, 2'd0, '0, 1'b0, 1'b1, 2'd0, 1'b0);
    chk("flm_data", {16'd0, out_data}, 32'h0022);
    chk("flm_tid", {30'd0, out_tid}, 32'd1);
    chk("flm_occ", {30'd0, occupancy}, 32'd1);

    // Drain FULL in order
    cyc(1'b1, 2'd2, 16'h0033, 1'b0, 1'b0, 2'd0, 1'b0);
    idle(1'b1);
    chk("pop1_rdy", {31'd0, in_ready}, 32'd1);
    chk("pop1_data", {16'd0, out_data}, 32'h0033);
    idle(1'b1);
    chk("pop2_occ", {30'd0, occupancy}, 32'd0);

    // flush_all with simultaneous output and input fire
    cyc(1'b1, 2'd3, 16'h0044, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc(1'b1, 2'd3, 16'h0055, 1'b1, 1'b0, 2'd0, 1'b1);
    chk("fa_occ", {30'd0, occupancy}, 32'd0);
    chk("fa_valid", {31'd0, out_valid}, 32'd0);

    // Non-matching flush, matching input discarded, skid-only flush
    cyc(1'b1, 2'd0, 16'h0066, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc(1'b0, 2'd0, '0, 1'b0, 1'b1, 2'd2, 1'b0);
    chk("nomatch_data", {16'd0, out_data}, 32'h0066);
    cyc(1'b1, 2'd1, 16'h0077, 1'b0, 1'b1, 2'd1, 1'b0);
    chk("indisc_occ", {30'd0, occupancy}, 32'd1);
    cyc(1'b1, 2'd2, 16'h0088, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc(1'b0, 2'd0, '0, 1'b0, 1'b1, 2'd2, 1'b0);
    chk("skidfl_occ", {30'd0, occupancy}, 32'd1);
    chk("skidfl_data", {16'd0, out_data}, 32'h0066);

    // Reset while FULL with an input pending
    cyc(1'b1, 2'd3, 16'h0099, 1'b0, 1'b0, 2'd0, 1'b0);
    do_reset(1'b1);

    // Random stress against the FIFO model
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1'b1);
      else cyc($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), W'($urandom),
               $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
               2'($urandom_range(0, 3)), $urandom_range(0, 49) == 0);
    end
    for (int c = 0; c < 4; c++) idle(1'b1);
    chk("drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rv_pipe_skid_reg.md
RV_PIPE_SKID_REG -- requirements
Module: rv_pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 256: payload width in bits.
REQ-002 Parameter TID_W, default 2: hardware-thread ID width (2**TID_W threads).
REQ-003 Parameter RESET_VAL, default 0: WIDTH-bit value loaded into all data registers at reset.
REQ-004 clk  in  1  single clock; all state SHALL update on posedge clk only.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  producer has a beat.
REQ-007 in_ready  out  1  block can accept a beat; driven from registered state only.
REQ-008 in_tid  in  TID_W  thread ID of the input beat.
REQ-009 in_data  in  WIDTH  input payload.
REQ-010 out_valid  out  1  output beat present; registered.
REQ-011 out_ready  in  1  consumer accepts the output beat.
REQ-012 out_tid  out  TID_W  thread ID of the output beat; registered.
REQ-013 out_data  out  WIDTH  output payload; registered, no combinational path from in_data.
REQ-014 flush_en  in  1  kill all beats of thread flush_tid.
REQ-015 flush_tid  in  TID_W  thread to kill.
REQ-016 flush_all  in  1  kill all beats, all threads.
REQ-017 occupancy  out  2  number of valid entries (0..2); registered.

Function
REQ-018 Storage SHALL be two entries: main (drives out_*) and skid; each holds valid, tid, data.
REQ-019 States SHALL be EMPTY (none valid), ONE (main only), FULL (main and skid); skid valid without main valid is illegal and SHALL never occur.
REQ-020 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, independent of out_ready (no ready combinational path).
REQ-021 Input fire = in_valid & in_ready; output fire = out_valid & out_ready.
REQ-022 EMPTY: input fire -> main loaded, ONE; latency in->out is exactly 1 cycle.
REQ-023 ONE: input and output fire -> main reloaded with input, stays ONE; input only -> skid loaded, FULL; output only -> EMPTY.
REQ-024 FULL: output fire -> main loaded from skid, skid invalid, ONE; no output fire -> hold.
REQ-025 Beat order SHALL be preserved; no beat duplicated or lost except by flush.
REQ-026 While out_valid=1 and out_ready=0 with no flush hitting main, out_tid/out_data SHALL remain stable.
REQ-027 Flush ordering per cycle: first compute next entries from handshake (REQ-022..024); then invalidate every next entry whose tid equals flush_tid (if flush_en) or all (if flush_all); then compact: if main invalid and skid valid, skid moves to main.
REQ-028 An output fire in a flush cycle SHALL complete (consumer keeps the beat); an input fire whose in_tid matches the flush SHALL be accepted and discarded.
REQ-029 flush_en with no matching entries SHALL leave state unchanged.
REQ-030 Data/tid registers SHALL load only when their entry is written; invalidation clears valid bits only.
REQ-031 occupancy SHALL equal main.valid + skid.valid after each update.

Reset
REQ-032 rst=1 at posedge: main/skid valid=0, tid=0, data=RESET_VAL; out_valid=0, occupancy=0, in_ready=1 in the following cycle.
REQ-033 rst SHALL override handshake and flush in the same cycle; beats in flight at reset are discarded.

Verification
REQ-034 Reset then in_valid=1, in_tid=1, in_data=0xA5, out_ready=1 -> next cycle out_valid=1, out_tid=1, out_data=0xA5, occupancy=1.
REQ-035 out_ready=0, push 0x11 then 0x22 -> occupancy=2, in_ready=0, out_data=0x11 held; out_ready=1 -> 0x11 then 0x22 out, in_ready=1 after first pop.
REQ-036 FULL with main tid=0 (0x11), skid tid=1 (0x22), flush_en=1 flush_tid=0, out_ready=0 -> next cycle out_data=0x22, out_tid=1, occupancy=1.
REQ-037 ONE, out_ready=1, flush_all=1, in_valid=1 -> output beat accepted, input discarded, next cycle occupancy=0, out_valid=0.
REQ-038 Random valid/ready/flush stress vs. per-thread FIFO scoreboard -> order preserved, flushed tids never emitted, occupancy never >2, in_ready=0 only when occupancy=2.
REQ-039 rst=1 while FULL with in_valid=1 -> next cycle out_valid=0, occupancy=0, out_data=RESET_VAL.
